// File: rtl/fifo_read_drainer.sv
// Read-side drainer for the pointer FIFO: pops when there is room, absorbs the
// one-cycle read latency in a 3-entry skid buffer and re-emits a framed stream.
module fifo_read_drainer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned FRAME_LEN = 4,
    parameter int unsigned COUNT_W   = 16
) (
    input  logic               out_clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               fifo_e,
    input  logic [WIDTH-1:0]   fifo_data,
    output logic               out_ready,
    output logic               m_valid,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_first,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy,
    output logic [COUNT_W-1:0] word_count,
    output logic [COUNT_W-1:0] frame_count
);

    localparam logic [15:0] IdxLast = 16'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         occ_q, occ_d;
    logic               inflight_q, inflight_d;
    logic [15:0]        idx_q, idx_d;
    logic [1:0]         head_q, head_d;
    logic [WIDTH-1:0]   buf_q [3];
    logic [WIDTH-1:0]   buf_d [3];
    logic [COUNT_W-1:0] word_count_q, word_count_d;
    logic [COUNT_W-1:0] frame_count_q, frame_count_d;

    logic       capture;
    logic       xfer;
    logic [1:0] tail;
    logic [2:0] pending;

    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    // Words popped but not yet delivered; a pop is only allowed if its word is guaranteed a slot.
    assign pending   = {1'b0, occ_q} + {2'b00, inflight_q};
    assign out_ready = (state_q == StRun) && !fifo_e && (pending < 3'd3);

    assign m_valid   = (occ_q != 2'd0);
    assign m_data    = m_valid ? buf_q[head_q] : '0;
    assign m_first   = m_valid && (idx_q == 16'd0);
    assign m_last    = m_valid && (idx_q == IdxLast);
    assign busy      = (state_q != StIdle);

    assign word_count  = word_count_q;
    assign frame_count = frame_count_q;

    assign capture = inflight_q;
    assign xfer    = m_valid && m_ready;
    assign tail    = wrap3({1'b0, head_q} + {1'b0, occ_q});

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (!enable) state_d = StDrain;
            end
            StDrain: begin
                if (enable) begin
                    state_d = StRun;
                end else if ((occ_q == 2'd0) && !inflight_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        buf_d         = buf_q;
        occ_d         = occ_q;
        head_d        = head_q;
        inflight_d    = out_ready;
        idx_d         = idx_q;
        word_count_d  = word_count_q;
        frame_count_d = frame_count_q;

        if (capture) begin
            buf_d[tail] = fifo_data;
        end

        unique case ({capture, xfer})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        if (xfer) begin
            head_d       = (head_q == 2'd2) ? 2'd0 : head_q + 2'd1;
            word_count_d = word_count_q + COUNT_W'(1);
            if (idx_q == IdxLast) begin
                idx_d         = 16'd0;
                frame_count_d = frame_count_q + COUNT_W'(1);
            end else begin
                idx_d = idx_q + 16'd1;
            end
        end
    end

    always_ff @(posedge out_clk) begin
        if (reset) begin
            state_q       <= StIdle;
            occ_q         <= 2'd0;
            inflight_q    <= 1'b0;
            idx_q         <= 16'd0;
            head_q        <= 2'd0;
            word_count_q  <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            occ_q         <= occ_d;
            inflight_q    <= inflight_d;
            idx_q         <= idx_d;
            head_q        <= head_d;
            word_count_q  <= word_count_d;
            frame_count_q <= frame_count_d;
        end
    end

    // Storage needs no reset: occupancy alone decides what is live.
    always_ff @(posedge out_clk) begin
        buf_q <= buf_d;
    end

endmodule
